// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the write-side (wptr_full) and read-side
// (rptr_empty) pointer blocks of the async FIFO.
//   depth_of(addrlen) : FIFO depth for a pointer of addrlen bits (one wrap bit)
//   bin2gray / gray2bin : code conversions. They work on 32-bit values, so any
//                         narrower pointer is zero-extended on the way in and
//                         cast back to its own width by the caller.
package fifo_pkg;

    function automatic int depth_of(input int addrlen);
        return 1 << (addrlen - 1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it. Zero
    // extension leaves the result of a narrow pointer unchanged.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_gray_counter.sv
// gray_counter: binary + Gray pointer register pair with synchronous reset.
// Advances by one when i_inc is set and i_hold is clear; both codes are
// registered so the Gray output feeds a synchronizer straight from flops.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_inc, i_hold  increment request / increment inhibit (e.g. full, empty)
//   o_gray         registered Gray pointer
//   o_addr         registered binary pointer without the wrap bit (RAM address)
//   o_bin_next     binary pointer value to be loaded on the next edge
//   o_gray_next    Gray pointer value to be loaded on the next edge
module gray_counter
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_hold,
    output logic [W-1:0] o_gray,
    output logic [W-2:0] o_addr,
    output logic [W-1:0] o_bin_next,
    output logic [W-1:0] o_gray_next
);

    logic [W-1:0] r_bin;
    logic [W-1:0] r_gray;
    logic         w_adv;

    assign w_adv       = i_inc & ~i_hold;
    // Wraps modulo 2**W without any special handling.
    assign o_bin_next  = r_bin + {{(W-1){1'b0}}, w_adv};
    assign o_gray_next = W'(bin2gray(32'(o_bin_next)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= o_bin_next;
            r_gray <= o_gray_next;
        end
    end

    assign o_gray = r_gray;
    assign o_addr = r_bin[W-2:0];

endmodule

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer and flag generator of the async FIFO.
// Owns the write counter, emits the Gray write pointer to the synchronizer and
// derives full / almost-full / occupancy / overflow from the synchronized Gray
// read pointer.
//   i_wclk, i_wrst    write clock, synchronous active-high reset
//   i_winc            write request
//   i_sync_rptr       Gray read pointer already synchronized into i_wclk
//   o_wptr            registered Gray write pointer (one bit changes per write)
//   o_waddr           RAM write address
//   o_wen             RAM write enable (write accepted this cycle)
//   o_wfull           registered full flag
//   o_walmost_full    registered, occupancy >= AFULL_THRESH
//   o_wcount          registered occupancy 0..DEPTH
//   o_wovf            sticky: write requested while full
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRLEN      = 4,
    parameter int AFULL_THRESH = 6
) (
    input  logic               i_wclk,
    input  logic               i_wrst,
    input  logic               i_winc,
    input  logic [ADDRLEN-1:0] i_sync_rptr,
    output logic [ADDRLEN-1:0] o_wptr,
    output logic [ADDRLEN-2:0] o_waddr,
    output logic               o_wen,
    output logic               o_wfull,
    output logic               o_walmost_full,
    output logic [ADDRLEN-1:0] o_wcount,
    output logic               o_wovf
);

    localparam logic [ADDRLEN-1:0] AFT = ADDRLEN'(AFULL_THRESH);

    logic [ADDRLEN-1:0] w_bin_next;
    logic [ADDRLEN-1:0] w_gray_next;
    logic [ADDRLEN-1:0] w_full_cmp;
    logic [ADDRLEN-1:0] w_rbin_s;
    logic [ADDRLEN-1:0] w_wcount_next;

    logic               r_wfull;
    logic               r_walmost_full;
    logic [ADDRLEN-1:0] r_wcount;
    logic               r_wovf;

    assign o_wen = i_winc & ~r_wfull;

    gray_counter #(.W(ADDRLEN)) u_wcnt (
        .i_clk       (i_wclk),
        .i_rst       (i_wrst),
        .i_inc       (i_winc),
        .i_hold      (r_wfull),
        .o_gray      (o_wptr),
        .o_addr      (o_waddr),
        .o_bin_next  (w_bin_next),
        .o_gray_next (w_gray_next)
    );

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the top two bits inverted, rest equal.
    assign w_full_cmp    = {~i_sync_rptr[ADDRLEN-1:ADDRLEN-2], i_sync_rptr[ADDRLEN-3:0]};

    // Occupancy uses the post-write pointer and the current synchronized read
    // pointer, so a write and a read advance on the same edge cancel out.
    assign w_rbin_s      = ADDRLEN'(gray2bin(32'(i_sync_rptr)));
    assign w_wcount_next = w_bin_next - w_rbin_s;

    always_ff @(posedge i_wclk) begin
        if (i_wrst) begin
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
            r_wovf         <= 1'b0;
        end else begin
            r_wfull        <= (w_gray_next == w_full_cmp);
            r_walmost_full <= (w_wcount_next >= AFT);
            r_wcount       <= w_wcount_next;
            r_wovf         <= r_wovf | (i_winc & r_wfull);
        end
    end

    assign o_wfull        = r_wfull;
    assign o_walmost_full = r_walmost_full;
    assign o_wcount       = r_wcount;
    assign o_wovf         = r_wovf;

endmodule

// File: tb/tb_wptr_full.sv
module tb_wptr_full;

    localparam int ADDRLEN = 4;
    localparam int DEPTH   = 8;
    localparam int AFT     = 6;

    logic       i_wclk;
    logic       i_wrst;
    logic       i_winc;
    logic [3:0] i_sync_rptr;
    logic [3:0] o_wptr;
    logic [2:0] o_waddr;
    logic       o_wen;
    logic       o_wfull;
    logic       o_walmost_full;
    logic [3:0] o_wcount;
    logic       o_wovf;

    wptr_full #(.ADDRLEN(ADDRLEN), .AFULL_THRESH(AFT)) dut (
        .i_wclk         (i_wclk),
        .i_wrst         (i_wrst),
        .i_winc         (i_winc),
        .i_sync_rptr    (i_sync_rptr),
        .o_wptr         (o_wptr),
        .o_waddr        (o_waddr),
        .o_wen          (o_wen),
        .o_wfull        (o_wfull),
        .o_walmost_full (o_walmost_full),
        .o_wcount       (o_wcount),
        .o_wovf         (o_wovf)
    );

    initial i_wclk = 1'b0;
    always #5 i_wclk = ~i_wclk;

    // Gray code of 0..15, written out as a table.
    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    int checks = 0;
    int errors = 0;

    // Reference model: total words written / read, flags from their difference.
    int m_wr   = 0;
    int m_rd   = 0;
    bit m_full = 0;
    bit m_afull = 0;
    int m_cnt  = 0;
    bit m_ovf  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check wen before the edge, advance the model,
    // check all registered outputs after the edge.
    task automatic cycle(input bit rst, input bit w, input int rd);
        i_wrst      = rst;
        i_winc      = w;
        m_rd        = rd;
        i_sync_rptr = gray_tab[rd % 16];
        #1;
        chk("wen", int'(o_wen), int'(w && !m_full));
        @(posedge i_wclk);
        #1;
        if (rst) begin
            m_wr = 0; m_full = 0; m_afull = 0; m_cnt = 0; m_ovf = 0;
        end else begin
            if (w && m_full) m_ovf = 1;
            if (w && !m_full) m_wr++;
            m_cnt   = m_wr - m_rd;
            m_full  = (m_cnt == DEPTH);
            m_afull = (m_cnt >= AFT);
        end
        chk("wptr",   int'(o_wptr),         int'(gray_tab[m_wr % 16]));
        chk("waddr",  int'(o_waddr),        m_wr % DEPTH);
        chk("wfull",  int'(o_wfull),        int'(m_full));
        chk("wafull", int'(o_walmost_full), int'(m_afull));
        chk("wcount", int'(o_wcount),       m_cnt);
        chk("wovf",   int'(o_wovf),         int'(m_ovf));
    endtask

    typedef struct {
        bit       winc;
        int       rd;
        bit       wen;
        bit [3:0] wptr;
        bit [2:0] waddr;
        bit       full;
        bit       afull;
        bit [3:0] cnt;
        bit       ovf;
    } vec_t;

    vec_t tbl [11];

    initial begin
        bit [3:0] prev;
        bit       saw_gray_wrap;
        bit       saw_addr_wrap;
        int       rd;

        // Fill, overflow and drain with hand-computed expectations.
        tbl[0]  = '{1, 0, 1, 4'b0001, 3'd1, 0, 0, 4'd1, 0};
        tbl[1]  = '{1, 0, 1, 4'b0011, 3'd2, 0, 0, 4'd2, 0};
        tbl[2]  = '{1, 0, 1, 4'b0010, 3'd3, 0, 0, 4'd3, 0};
        tbl[3]  = '{1, 0, 1, 4'b0110, 3'd4, 0, 0, 4'd4, 0};
        tbl[4]  = '{1, 0, 1, 4'b0111, 3'd5, 0, 0, 4'd5, 0};
        tbl[5]  = '{1, 0, 1, 4'b0101, 3'd6, 0, 1, 4'd6, 0};
        tbl[6]  = '{1, 0, 1, 4'b0100, 3'd7, 0, 1, 4'd7, 0};
        tbl[7]  = '{1, 0, 1, 4'b1100, 3'd0, 1, 1, 4'd8, 0};
        tbl[8]  = '{1, 0, 0, 4'b1100, 3'd0, 1, 1, 4'd8, 1};
        tbl[9]  = '{0, 2, 0, 4'b1100, 3'd0, 0, 1, 4'd6, 1};
        tbl[10] = '{0, 2, 0, 4'b1100, 3'd0, 0, 1, 4'd6, 1};

        i_wrst = 1; i_winc = 1; i_sync_rptr = 0;

        // Reset held two cycles with winc asserted.
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("rst_wptr",  int'(o_wptr),   0);
        chk("rst_waddr", int'(o_waddr),  0);
        chk("rst_wfull", int'(o_wfull),  0);
        chk("rst_wcnt",  int'(o_wcount), 0);
        chk("rst_wovf",  int'(o_wovf),   0);

        for (int i = 0; i < 11; i++) begin
            i_wrst = 0; i_winc = tbl[i].winc; i_sync_rptr = gray_tab[tbl[i].rd];
            #1;
            chk($sformatf("tbl%0d_wen", i), int'(o_wen), int'(tbl[i].wen));
            cycle(0, tbl[i].winc, tbl[i].rd);
            chk($sformatf("tbl%0d_wptr", i),  int'(o_wptr),         int'(tbl[i].wptr));
            chk($sformatf("tbl%0d_waddr", i), int'(o_waddr),        int'(tbl[i].waddr));
            chk($sformatf("tbl%0d_full", i),  int'(o_wfull),        int'(tbl[i].full));
            chk($sformatf("tbl%0d_afull", i), int'(o_walmost_full), int'(tbl[i].afull));
            chk($sformatf("tbl%0d_cnt", i),   int'(o_wcount),       int'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ovf", i),   int'(o_wovf),         int'(tbl[i].ovf));
        end

        // Wrap: 20 writes with the read pointer trailing by two.
        cycle(1, 0, 0);
        saw_gray_wrap = 0;
        saw_addr_wrap = 0;
        for (int k = 0; k < 20; k++) begin
            prev = o_wptr;
            rd = (m_wr > 2) ? m_wr - 2 : 0;
            cycle(0, 1, rd);
            chk("wrap_full", int'(o_wfull), 0);
            chk("wrap_1bit", $countones(o_wptr ^ prev), 1);
            if (prev == 4'b1000 && o_wptr == 4'b0000) saw_gray_wrap = 1;
            if (o_waddr == 3'd0 && k > 0) saw_addr_wrap = 1;
        end
        chk("wrap_gray_seen", int'(saw_gray_wrap), 1);
        chk("wrap_addr_seen", int'(saw_addr_wrap), 1);

        // Reset in the middle of a burst, then resume from zero.
        cycle(1, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 1, 0);
        cycle(1, 1, 0);
        chk("mid_wptr",  int'(o_wptr),   0);
        chk("mid_waddr", int'(o_waddr),  0);
        chk("mid_wcnt",  int'(o_wcount), 0);
        chk("mid_wfull", int'(o_wfull),  0);
        cycle(0, 1, 0);
        chk("resume_wptr", int'(o_wptr),   1);
        chk("resume_wcnt", int'(o_wcount), 1);

        // Random traffic against the model; reads only consume written words.
        rd = m_rd;
        for (int k = 0; k < 400; k++) begin
            bit rst;
            bit w;
            rst = ($urandom_range(0, 99) == 0);
            w   = ($urandom_range(0, 3) != 0);
            if (rst) rd = 0;
            else if (rd < m_wr && $urandom_range(0, 2) == 0)
                rd = rd + int'($urandom_range(1, m_wr - rd));
            cycle(rst, w, rd);
            if (rst) rd = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
